// File: rtl/gpio_uart_pkg.sv
// gpio_uart_pkg: shared UART FSM state type and default parameters for the GPIO-to-UART bridge
package gpio_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte-wide synchronous FIFO; a push is still taken when full if a pop happens the same cycle
// ports: clk, rst (sync, active-high), push_i/data_i write side, pop_i/data_o read side (data_o = head),
//        full_o/empty_o occupancy flags
module byte_fifo
  import gpio_uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic wr_en, rd_en;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + AW'(1);
      end
      if (rd_en) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: assembles GPIO bits (LSB first) into bytes, queues them and sends them as 8N1 UART frames
// ports: clk, reset (sync, active-high), GPIO data bit, GPIOBoolean bit strobe,
//        tx serial line (registered, idle high), busy, fifo_full, overflow (sticky drop flag)
module gpio_uart_tx
  import gpio_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic GPIO,
  input  logic GPIOBoolean,
  output logic tx,
  output logic busy,
  output logic fifo_full,
  output logic overflow
);
  localparam logic [15:0] BAUD_TC = 16'(CLKS_PER_BIT - 1);
  uart_state_e state_q;
  logic [7:0] asm_q, shift_q, push_byte, head;
  logic [2:0] bit_cnt_q, data_idx_q;
  logic [15:0] baud_q;
  logic tx_q, ovf_q, push, pop, empty, baud_tc;
  assign push = GPIOBoolean && bit_cnt_q == 3'd7;
  assign push_byte = {GPIO, asm_q[7:1]};
  assign pop = state_q == IDLE && !empty;
  assign baud_tc = baud_q == BAUD_TC;
  assign tx = tx_q;
  assign busy = state_q != IDLE || !empty;
  assign overflow = ovf_q;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .pop_i(pop),
    .data_i(push_byte),
    .data_o(head),
    .full_o(fifo_full),
    .empty_o(empty)
  );
  // new bits enter at the MSB so the first bit ends up at bit 0 after eight strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      bit_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (GPIOBoolean) begin
      asm_q <= push_byte;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      baud_q <= '0;
      data_idx_q <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!empty) begin
          shift_q <= head;
          tx_q <= 1'b0;
          baud_q <= '0;
          state_q <= START;
        end
        START: if (baud_tc) begin
          baud_q <= '0;
          tx_q <= shift_q[0];
          data_idx_q <= '0;
          state_q <= DATA;
        end else baud_q <= baud_q + 16'd1;
        DATA: if (baud_tc) begin
          baud_q <= '0;
          shift_q <= {1'b0, shift_q[7:1]};
          tx_q <= data_idx_q == 3'd7 ? 1'b1 : shift_q[1];
          data_idx_q <= data_idx_q + 3'd1;
          if (data_idx_q == 3'd7) state_q <= STOP;
        end else baud_q <= baud_q + 16'd1;
        STOP: if (baud_tc) begin
          baud_q <= '0;
          state_q <= IDLE;
        end else baud_q <= baud_q + 16'd1;
      endcase
    end
  end
endmodule
